axi_slave_ram_burst: RTL and testbench
======================================

Name: axi_slave_ram_burst

Overview:
Parametrised AXI4 slave RAM with independent read and write channel engines. It supports FIXED, INCR and WRAP bursts, narrow transfers, write strobes and error responses. It is a byte-addressed memory model for the AXI demo fabric, replacing the read-only INCR-only slave. One outstanding burst per direction; no IDs.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8/16/32/64/128)
STROBE_WIDTH, DATA_WIDTH/8, byte lanes per beat
ADDRESS_WIDTH, 8, byte address width; memory holds 2**ADDRESS_WIDTH bytes

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
awaddr  in  ADDRESS_WIDTH  write burst start byte address
awlen  in  8  beats-1
awsize  in  3  log2 bytes per beat
awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
awvalid/awready  in/out  1/1  write address handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  STROBE_WIDTH  byte-lane enables
wlast  in  1  master's last-beat marker
wvalid/wready  in/out  1/1  write data handshake
bresp  out  2  0 OKAY, 2 SLVERR
bvalid/bready  out/in  1/1  write response handshake
araddr, arlen, arsize, arburst  in  ADDRESS_WIDTH,8,3,2  read burst descriptor (same encodings)
arvalid/arready  in/out  1/1  read address handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  0 OKAY, 2 SLVERR
rlast  out  1  final beat of burst
rvalid/rready  out/in  1/1  read data handshake

Behaviour:
- Reset (async, immediate): awready=1, wready=0, bvalid=0, bresp=0, arready=1, rvalid=0, rlast=0, rresp=0, rdata=0. Memory contents are not reset. Reset mid-burst abandons the burst; bytes already written are retained.
- Transfer bytes N=2**size; beat count = len+1, counted internally (never from wlast).
- Burst error (SLVERR, all beats still handshaken, no memory write, read data 0):
  - size > log2(STROBE_WIDTH)
  - burst==3
  - WRAP with len not in {1,3,7,15}
  - WRAP with unaligned start address
- Address sequence:
  - FIXED: every beat at the start address.
  - INCR: beat 0 at the start address; beat k at aligned_start + k*N. Wraps modulo 2**ADDRESS_WIDTH.
  - WRAP: boundary = floor(start/(N*(len+1)))*(N*(len+1)); next = boundary + ((addr+N-boundary) mod (N*(len+1))).
- Lanes: byte at address a uses lane a mod STROBE_WIDTH. A beat's active lanes run from the lane of addr up to the lane of the N-aligned upper bound of addr.
- Write FSM:
  - W_IDLE (awready=1, wready=0): on AW handshake, capture the descriptor and go to W_DATA.
  - W_DATA (awready=0, wready=1): each W handshake writes active lanes with wstrb=1.
  - A response error latches SLVERR if wlast=1 on a non-final beat or wlast=0 on the final beat; writes still occur.
  - After the final beat, go to W_RESP.
  - W_RESP: bvalid=1, bresp held until bready; then W_IDLE, with awready=1 the next cycle.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, go to R_DATA.
  - R_DATA: rvalid=1 from the cycle after the AR handshake.
  - rdata carries active lanes from memory; inactive lanes are 0.
  - rlast=1 on the final beat.
  - rdata, rresp and rlast are held stable while rvalid=1 and rready=0.
  - On each R handshake, the next beat is presented the following cycle (1 beat/cycle sustained).
  - After the final handshake, return to R_IDLE; arready=1 the next cycle.
- Read and write engines run concurrently. A read and a write to the same byte in the same cycle: read returns the old value.

Test Plan:
1. AW addr=0x10, len=3, size=2, INCR; W 0xA0A0A0A0..0xA3A3A3A3, wstrb=0xF; then AR same -> bresp=0; 4 R beats equal to the write data; rlast only on beat 4; rresp=0.
2. Preload 0x10-0x1F; AR addr=0x18, len=3, size=2, WRAP -> beats from 0x18, 0x1C, 0x10, 0x14.
3. AW addr=0x21, len=1, size=0, INCR; wdata=0x0000AB00 then 0x00CD0000, wstrb=0xF -> only 0x21=0xAB and 0x22=0xCD change; AR 0x20 size=2 returns 0x00CDAB00 if bytes 0x20/0x23 were zero.
4. AR addr=0x40, len=2, FIXED; rready low 2 cycles mid-burst -> same word 3 times; rdata/rlast stable during the stall; arready low until after the final beat.
5. Write len=3 with wlast on beat 2 -> bresp=2; AR size=3 (32-bit bus) len=1 -> 2 beats, rresp=2, rdata=0.
6. Assert areset during beat 2 of a 4-beat read -> rvalid=0 immediately; after release arready=1; a new burst completes normally.

Source files
------------

// File: rtl/axi_slave_ram_burst.sv
// Byte-addressed AXI4 slave RAM with independent read and write burst engines.
// Supports FIXED/INCR/WRAP bursts, narrow beats, write strobes and SLVERR responses.
module axi_slave_ram_burst #(
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [7:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awburst,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STROBE_WIDTH-1:0]  wstrb,
    input  logic                     wlast,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [1:0]               dbg_wr_state_o,
    output logic [1:0]               dbg_rd_state_o
);

    localparam int SW       = STROBE_WIDTH;
    localparam int AW       = ADDRESS_WIDTH;
    localparam int DEPTH    = 1 << AW;
    localparam int MAX_SIZE = $clog2(SW);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA} rd_state_e;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a source holds valid and its payload stable until that edge.

    logic [7:0] mem [DEPTH];

    function automatic logic burst_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] nmask;
        logic          err;
        nmask = AW'((32'd1 << size) - 32'd1);
        err   = (int'(size) > MAX_SIZE) || (burst == 2'd3);
        if (burst == BURST_WRAP) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
            if ((addr & nmask) != '0) err = 1'b1;
        end
        return err;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] n;
        logic [AW-1:0] nmask;
        logic [AW-1:0] wmask;
        logic [AW-1:0] nxt;
        n     = AW'(32'd1 << size);
        nmask = AW'((32'd1 << size) - 32'd1);
        // Wrap window is N*(len+1) bytes; both factors are powers of two for legal WRAP bursts.
        wmask = AW'(((32'd1 << size) * (32'(len) + 32'd1)) - 32'd1);
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~wmask) | ((addr + n) & wmask);
            default:     nxt = (addr & ~nmask) + n;
        endcase
        return nxt;
    endfunction

    function automatic logic [SW-1:0] lane_mask(input logic [AW-1:0] addr, input logic [2:0] size);
        int            a;
        int            n;
        int            lo;
        int            hi;
        logic [SW-1:0] m;
        a  = int'(addr);
        n  = 1 << size;
        lo = a % SW;
        hi = ((a & ~(n - 1)) + n - 1) % SW;
        for (int l = 0; l < SW; l++) m[l] = (l >= lo) && (l <= hi);
        return m;
    endfunction

    // Write engine state
    wr_state_e     wr_state_q;
    logic          awready_q, wready_q, bvalid_q;
    logic [1:0]    bresp_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_len_q, wr_idx_q;
    logic [2:0]    wr_size_q;
    logic [1:0]    wr_burst_q;
    logic          wr_err_q, wr_resp_err_q;

    logic          wr_fire;
    logic          wr_last;
    logic [SW-1:0] wr_mask;
    logic [AW-1:0] wr_base;

    always_comb begin
        wr_fire = wvalid && wready_q;
        wr_last = (wr_idx_q == wr_len_q);
        wr_mask = lane_mask(wr_addr_q, wr_size_q) & wstrb;
        wr_base = wr_addr_q & ~AW'(SW - 1);
    end

    always_ff @(posedge aclk) begin
        if (wr_fire && !wr_err_q) begin
            for (int l = 0; l < SW; l++) begin
                if (wr_mask[l]) mem[wr_base + AW'(l)] <= wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q    <= W_IDLE;
            awready_q     <= 1'b1;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            wr_idx_q      <= '0;
            wr_size_q     <= '0;
            wr_burst_q    <= '0;
            wr_err_q      <= 1'b0;
            wr_resp_err_q <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awvalid) begin
                        wr_addr_q     <= awaddr;
                        wr_len_q      <= awlen;
                        wr_size_q     <= awsize;
                        wr_burst_q    <= awburst;
                        wr_err_q      <= burst_err(awaddr, awlen, awsize, awburst);
                        wr_resp_err_q <= 1'b0;
                        wr_idx_q      <= '0;
                        awready_q     <= 1'b0;
                        wready_q      <= 1'b1;
                        wr_state_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        wr_addr_q <= next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
                        wr_idx_q  <= wr_idx_q + 8'd1;
                        // Beat count comes from len; wlast only feeds the response.
                        if (wr_last) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_err_q || wr_resp_err_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= W_RESP;
                        end else if (wlast) begin
                            wr_resp_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= RESP_OKAY;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read engine state
    rd_state_e       rd_state_q;
    logic            arready_q, rvalid_q, rlast_q;
    logic [1:0]      rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [AW-1:0]   rd_addr_q;
    logic [7:0]      rd_len_q, rd_idx_q;
    logic [2:0]      rd_size_q;
    logic [1:0]      rd_burst_q;
    logic            rd_err_q;

    logic [AW-1:0]   rd_nxt;
    logic [AW-1:0]   fetch_addr;
    logic [AW-1:0]   fetch_base;
    logic [2:0]      fetch_size;
    logic            fetch_err;
    logic [SW-1:0]   fetch_mask;
    logic [DATA_WIDTH-1:0] fetch_data;

    // In idle the fetch looks at the incoming AR so beat 0 is ready the cycle after the handshake.
    always_comb begin
        rd_nxt     = next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
        fetch_addr = (rd_state_q == R_IDLE) ? araddr : rd_nxt;
        fetch_size = (rd_state_q == R_IDLE) ? arsize : rd_size_q;
        fetch_err  = (rd_state_q == R_IDLE) ? burst_err(araddr, arlen, arsize, arburst) : rd_err_q;
        fetch_mask = lane_mask(fetch_addr, fetch_size);
        fetch_base = fetch_addr & ~AW'(SW - 1);
        fetch_data = '0;
        if (!fetch_err) begin
            for (int l = 0; l < SW; l++) begin
                if (fetch_mask[l]) fetch_data[8*l +: 8] = mem[fetch_base + AW'(l)];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_idx_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        rd_addr_q  <= araddr;
                        rd_len_q   <= arlen;
                        rd_size_q  <= arsize;
                        rd_burst_q <= arburst;
                        rd_err_q   <= fetch_err;
                        rd_idx_q   <= '0;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= fetch_data;
                        rresp_q    <= fetch_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q    <= (arlen == 8'd0);
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            rresp_q    <= RESP_OKAY;
                            rdata_q    <= '0;
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_addr_q <= rd_nxt;
                            rd_idx_q  <= rd_idx_q + 8'd1;
                            rdata_q   <= fetch_data;
                            rlast_q   <= ((rd_idx_q + 8'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign awready        = awready_q;
    assign wready         = wready_q;
    assign bvalid         = bvalid_q;
    assign bresp          = bresp_q;
    assign arready        = arready_q;
    assign rvalid         = rvalid_q;
    assign rlast          = rlast_q;
    assign rresp          = rresp_q;
    assign rdata          = rdata_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi_slave_ram_burst.sv
// Directed bench for axi_slave_ram_burst: write/read bursts with an expected-beat queue
// checked as the read channel produces data.
module tb_axi_slave_ram_burst;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int AW = 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [1:0]    dbg_wr_state;
    logic [1:0]    dbg_rd_state;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Expected read beats: {rresp, rlast, rdata}
    logic [DW+2:0] exp_q[$];
    logic [DW-1:0] wd_q[$];

    axi_slave_ram_burst #(.DATA_WIDTH(DW), .STROBE_WIDTH(SW), .ADDRESS_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors_applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        exp_q.push_back({resp, last, d});
    endtask

    task automatic drive_aw(input logic [7:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int guard = 0;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && guard < 50) begin @(negedge aclk); guard++; end
        check("aw_handshake", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [7:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int guard = 0;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (arready !== 1'b1 && guard < 50) begin @(negedge aclk); guard++; end
        check("ar_handshake", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb, input int wlast_beat,
                            input logic [1:0] exp_resp);
        int guard;
        drive_aw(addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = wd_q.pop_front();
            wstrb  = strb;
            wlast  = (wlast_beat < 0) ? (b == int'(len)) : (b == wlast_beat);
            wvalid = 1'b1;
            guard  = 0;
            while (wready !== 1'b1 && guard < 50) begin @(negedge aclk); guard++; end
            check("w_ready", wready, 1);
            @(negedge aclk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        guard  = 0;
        while (bvalid !== 1'b1 && guard < 50) begin @(negedge aclk); guard++; end
        check("b_valid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("w_ready_in_resp", wready, 0);
        @(negedge aclk);
        bready = 1'b0;
        check("aw_ready_after_b", awready, 1);
        check("wr_state_idle", dbg_wr_state, 0);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_beat);
        int beat  = 0;
        int guard = 0;
        logic [DW+2:0] exp;
        drive_ar(addr, len, size, burst);
        rready = 1'b1;
        while (beat <= int'(len) && guard < 200) begin
            if (rvalid === 1'b1) begin
                if (beat == stall_beat) begin
                    rready = 1'b0;
                    for (int s = 0; s < 2; s++) begin
                        @(negedge aclk);
                        check("r_stall_hold", {rresp, rlast, rdata}, exp_q[0]);
                    end
                    rready = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("r_unexpected_beat", beat, -1);
                end else begin
                    exp = exp_q.pop_front();
                    check("r_beat", {rresp, rlast, rdata}, exp);
                end
                check("ar_busy", arready, 0);
                beat++;
            end
            @(negedge aclk);
            guard++;
        end
        rready = 1'b0;
        check("r_beat_count", beat, int'(len) + 1);
        check("ar_ready_after_r", arready, 1);
        check("r_valid_after_r", rvalid, 0);
        check("rd_state_idle", dbg_rd_state, 0);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_arready", arready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        areset = 1'b0;
        @(negedge aclk);

        // INCR word write then read back
        wd_q = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
        do_write(8'h10, 8'd3, 3'd2, 2'd1, 4'hF, -1, 2'd0);
        push_exp(32'hA0A0A0A0, 2'd0, 1'b0);
        push_exp(32'hA1A1A1A1, 2'd0, 1'b0);
        push_exp(32'hA2A2A2A2, 2'd0, 1'b0);
        push_exp(32'hA3A3A3A3, 2'd0, 1'b1);
        do_read(8'h10, 8'd3, 3'd2, 2'd1, -1);

        // WRAP read starting mid-window
        wd_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        do_write(8'h10, 8'd3, 3'd2, 2'd1, 4'hF, -1, 2'd0);
        push_exp(32'h0B0A0908, 2'd0, 1'b0);
        push_exp(32'h0F0E0D0C, 2'd0, 1'b0);
        push_exp(32'h03020100, 2'd0, 1'b0);
        push_exp(32'h07060504, 2'd0, 1'b1);
        do_read(8'h18, 8'd3, 3'd2, 2'd2, -1);

        // Narrow byte writes touch only their own lanes
        wd_q = '{32'h00000000};
        do_write(8'h20, 8'd0, 3'd2, 2'd1, 4'hF, -1, 2'd0);
        wd_q = '{32'h0000AB00, 32'h00CD0000};
        do_write(8'h21, 8'd1, 3'd0, 2'd1, 4'hF, -1, 2'd0);
        push_exp(32'h00CDAB00, 2'd0, 1'b1);
        do_read(8'h20, 8'd0, 3'd2, 2'd1, -1);
        push_exp(32'h0000AB00, 2'd0, 1'b0);
        push_exp(32'h00CD0000, 2'd0, 1'b1);
        do_read(8'h21, 8'd1, 3'd0, 2'd1, -1);

        // FIXED read with a two-cycle stall in the middle
        wd_q = '{32'h5A5A1234};
        do_write(8'h40, 8'd0, 3'd2, 2'd1, 4'hF, -1, 2'd0);
        push_exp(32'h5A5A1234, 2'd0, 1'b0);
        push_exp(32'h5A5A1234, 2'd0, 1'b0);
        push_exp(32'h5A5A1234, 2'd0, 1'b1);
        do_read(8'h40, 8'd2, 3'd2, 2'd0, 1);

        // FIXED write: last beat wins
        wd_q = '{32'h00000001, 32'h00000002, 32'h00000003};
        do_write(8'h44, 8'd2, 3'd2, 2'd0, 4'hF, -1, 2'd0);
        push_exp(32'h00000003, 2'd0, 1'b1);
        do_read(8'h44, 8'd0, 3'd2, 2'd1, -1);

        // Early wlast: SLVERR but data still lands
        wd_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_write(8'h50, 8'd3, 3'd2, 2'd1, 4'hF, 1, 2'd2);
        push_exp(32'h11111111, 2'd0, 1'b0);
        push_exp(32'h22222222, 2'd0, 1'b0);
        push_exp(32'h33333333, 2'd0, 1'b0);
        push_exp(32'h44444444, 2'd0, 1'b1);
        do_read(8'h50, 8'd3, 3'd2, 2'd1, -1);

        // Oversized read: all beats handshaken with SLVERR and zero data
        push_exp(32'h0, 2'd2, 1'b0);
        push_exp(32'h0, 2'd2, 1'b1);
        do_read(8'h50, 8'd1, 3'd3, 2'd1, -1);

        // Partial strobes
        wd_q = '{32'hFFFFFFFF};
        do_write(8'h50, 8'd0, 3'd2, 2'd1, 4'b0101, -1, 2'd0);

        // Illegal write bursts must not modify memory
        wd_q = '{32'hFEEDFACE};
        do_write(8'h50, 8'd0, 3'd3, 2'd1, 4'hF, -1, 2'd2);
        wd_q = '{32'hFEEDFACE, 32'hFEEDFACE};
        do_write(8'h52, 8'd1, 3'd2, 2'd2, 4'hF, -1, 2'd2);
        wd_q = '{32'hFEEDFACE};
        do_write(8'h50, 8'd0, 3'd2, 2'd3, 4'hF, -1, 2'd2);
        push_exp(32'h11FF11FF, 2'd0, 1'b0);
        push_exp(32'h22222222, 2'd0, 1'b1);
        do_read(8'h50, 8'd1, 3'd2, 2'd1, -1);

        // Illegal read bursts: WRAP len 2, reserved burst type
        push_exp(32'h0, 2'd2, 1'b0);
        push_exp(32'h0, 2'd2, 1'b0);
        push_exp(32'h0, 2'd2, 1'b1);
        do_read(8'h10, 8'd2, 3'd2, 2'd2, -1);
        push_exp(32'h0, 2'd2, 1'b1);
        do_read(8'h10, 8'd0, 3'd2, 2'd3, -1);

        // INCR wraps at the top of the address space
        wd_q = '{32'hCAFEF00D, 32'h0BADBEEF};
        do_write(8'hFC, 8'd1, 3'd2, 2'd1, 4'hF, -1, 2'd0);
        push_exp(32'hCAFEF00D, 2'd0, 1'b0);
        push_exp(32'h0BADBEEF, 2'd0, 1'b1);
        do_read(8'hFC, 8'd1, 3'd2, 2'd1, -1);
        push_exp(32'h0BADBEEF, 2'd0, 1'b1);
        do_read(8'h00, 8'd0, 3'd2, 2'd1, -1);

        // Reset in the middle of a read burst
        drive_ar(8'h10, 8'd3, 3'd2, 2'd1);
        rready = 1'b1;
        check("rr_beat0", rdata, 32'h03020100);
        @(negedge aclk);
        check("rr_beat1", rdata, 32'h07060504);
        areset = 1'b1;
        #1;
        check("rr_rvalid", rvalid, 0);
        check("rr_rlast", rlast, 0);
        check("rr_rdata", rdata, 0);
        check("rr_arready", arready, 1);
        check("rr_awready", awready, 1);
        rready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("rr_arready_after", arready, 1);
        push_exp(32'h03020100, 2'd0, 1'b0);
        push_exp(32'h07060504, 2'd0, 1'b0);
        push_exp(32'h0B0A0908, 2'd0, 1'b0);
        push_exp(32'h0F0E0D0C, 2'd0, 1'b1);
        do_read(8'h10, 8'd3, 3'd2, 2'd1, -1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
